dec7seg_scan: RTL and testbench

- Parametrised successor of the single-digit hex-to-7-segment decoder.
- Drives NUM_DIGITS common-anode/cathode digits from one shared segment bus by time-multiplexed scanning.
- Adds tear-free frame-synchronous value loading, per-digit blanking, decimal points, leading-zero suppression and anti-ghosting guard time.
- Sits between the game/score logic and the board display pins.

---
 rtl/dec7seg_scan.sv | 192 +++++++++++++++++++
 tb/tb_dec7seg_scan.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dec7seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : dec7seg_scan
// Description : Time-multiplexed multi-digit hex 7-segment display driver with
//               frame-synchronous value loading, per-digit blanking, decimal
//               points, leading-zero suppression and anti-ghosting guard time.
// Revision    : 1.0 - initial release
// ============================================================================
module dec7seg_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int GUARD_CYC      = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic                    load_i,
    input  logic                    lz_en_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] c_CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] c_GUARD   = CW'(GUARD_CYC);
    localparam logic [IW-1:0] c_IDX_MAX = IW'(NUM_DIGITS - 1);

    // XOR masks that convert active-high internal values to pin polarity;
    // they are also the "everything dark" pin values.
    localparam logic [6:0]            c_SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  c_DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] c_AN_OFF  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                                : {NUM_DIGITS{1'b0}};

    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_sh_val;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blank;
    logic                    r_pending;
    logic [4*NUM_DIGITS-1:0] r_dsp_val;
    logic [NUM_DIGITS-1:0]   r_dsp_dp;
    logic [NUM_DIGITS-1:0]   r_dsp_blank;

    logic                    w_slot_end;
    logic                    w_boundary;
    logic [NUM_DIGITS-1:0]   w_lz_sup;
    logic                    w_hi_zero;
    logic [3:0]              w_nib;
    logic                    w_cur_dp;
    logic                    w_cur_blank;
    logic                    w_cur_sup;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [6:0]              w_glyph;
    logic [6:0]              w_seg_act;
    logic                    w_dp_act;
    logic [NUM_DIGITS-1:0]   w_an_act;

    assign w_slot_end = (r_cnt == c_CNT_MAX);
    assign w_boundary = w_slot_end && (r_idx == c_IDX_MAX);
    assign frame_o    = w_boundary;

    // Prescaler and digit index: one slot per SCAN_DIV cycles, digits in order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Shadow/display registers: display only changes at the frame boundary,
    // and a load coinciding with the boundary bypasses the shadow stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sh_val    <= '0;
            r_sh_dp     <= '0;
            r_sh_blank  <= '0;
            r_pending   <= 1'b0;
            r_dsp_val   <= '0;
            r_dsp_dp    <= '0;
            r_dsp_blank <= '0;
        end else begin
            if (load_i) begin
                r_sh_val   <= value_i;
                r_sh_dp    <= dp_i;
                r_sh_blank <= blank_i;
            end
            if (load_i && w_boundary) begin
                r_dsp_val   <= value_i;
                r_dsp_dp    <= dp_i;
                r_dsp_blank <= blank_i;
                r_pending   <= 1'b0;
            end else if (load_i) begin
                r_pending   <= 1'b1;
            end else if (w_boundary && r_pending) begin
                r_dsp_val   <= r_sh_val;
                r_dsp_dp    <= r_sh_dp;
                r_dsp_blank <= r_sh_blank;
                r_pending   <= 1'b0;
            end
        end
    end

    // Leading-zero mask: walk from the top digit down while nibbles stay zero.
    always_comb begin
        w_lz_sup  = '0;
        w_hi_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_hi_zero = w_hi_zero & (r_dsp_val[4*k +: 4] == 4'h0);
            if (k > 0) begin
                w_lz_sup[k] = lz_en_i & w_hi_zero;
            end
        end
    end

    // Pick out the attributes of the digit owning the current slot.
    always_comb begin
        w_nib       = 4'h0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b0;
        w_cur_sup   = 1'b0;
        w_onehot    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_nib       = r_dsp_val[4*k +: 4];
                w_cur_dp    = r_dsp_dp[k];
                w_cur_blank = r_dsp_blank[k];
                w_cur_sup   = w_lz_sup[k];
                w_onehot[k] = 1'b1;
            end
        end
    end

    // Hex glyph lookup, gfedcba active-high.
    always_comb begin
        w_glyph = 7'h00;
        case (w_nib)
            4'h0: w_glyph = 7'h3F;
            4'h1: w_glyph = 7'h06;
            4'h2: w_glyph = 7'h5B;
            4'h3: w_glyph = 7'h4F;
            4'h4: w_glyph = 7'h66;
            4'h5: w_glyph = 7'h6D;
            4'h6: w_glyph = 7'h7D;
            4'h7: w_glyph = 7'h07;
            4'h8: w_glyph = 7'h7F;
            4'h9: w_glyph = 7'h6F;
            4'hA: w_glyph = 7'h77;
            4'hB: w_glyph = 7'h7C;
            4'hC: w_glyph = 7'h39;
            4'hD: w_glyph = 7'h5E;
            4'hE: w_glyph = 7'h79;
            default: w_glyph = 7'h71;
        endcase
    end

    // Active-high next output values; segments pre-settle during the guard
    // window while every anode is held off.
    always_comb begin
        w_seg_act = (w_cur_blank || w_cur_sup) ? 7'h00 : w_glyph;
        w_dp_act  = w_cur_dp & ~w_cur_blank;
        w_an_act  = (w_cur_blank || (r_cnt < c_GUARD)) ? '0 : w_onehot;
    end

    // Output register with pin polarity applied.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seg_o <= c_SEG_OFF;
            dp_o  <= c_DP_OFF;
            an_o  <= c_AN_OFF;
        end else begin
            seg_o <= w_seg_act ^ c_SEG_OFF;
            dp_o  <= w_dp_act ^ c_DP_OFF;
            an_o  <= w_an_act ^ c_AN_OFF;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dec7seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_dec7seg_scan
// Description : Self-checking bench for dec7seg_scan (4 digits, 8-cycle slots,
//               2-cycle guard, active-low pins) against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dec7seg_scan;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int GUARD = 2;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic        load = 1'b0;
    logic        lz = 1'b0;
    logic [6:0]  seg;
    logic        dpo;
    logic [3:0]  an;
    logic        frame;

    int tests = 0;
    int fails = 0;

    // Model: cycle number since reset plus displayed/shadow contents.
    int          k = 0;
    logic [15:0] m_dv = '0, m_sv = '0;
    logic [3:0]  m_dd = '0, m_sd = '0, m_db = '0, m_sb = '0;
    bit          m_pend = 1'b0;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    dec7seg_scan #(
        .NUM_DIGITS    (N),
        .SCAN_DIV      (DIV),
        .GUARD_CYC     (GUARD),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) u_dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .value_i(value),
        .dp_i   (dp),
        .blank_i(blank),
        .load_i (load),
        .lz_en_i(lz),
        .seg_o  (seg),
        .dp_o   (dpo),
        .an_o   (an),
        .frame_o(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at cycle %0d: observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_seg"}, {1'b0, seg}, 8'h7F);
        chk({tag, "_dp"}, {7'b0, dpo}, 8'h01);
        chk({tag, "_an"}, {4'b0, an}, 8'h0F);
        chk({tag, "_frame"}, {7'b0, frame}, 8'h00);
    endtask

    // One clock: predict the registered outputs from the current cycle, apply
    // the load rules, clock, then compare.
    task automatic step();
        int slot_pos, digit;
        logic [3:0] nib;
        logic [6:0] es;
        logic       edp;
        logic [3:0] ean;
        bit         sup, bnd;
        slot_pos = k % DIV;
        digit    = (k / DIV) % N;
        nib      = 4'(m_dv >> (4 * digit));
        sup      = lz && (digit > 0) && ((m_dv >> (4 * digit)) == 16'h0);
        if (m_db[digit]) begin
            es = 7'h00; edp = 1'b0; ean = 4'h0;
        end else begin
            es  = sup ? 7'h00 : glyph[nib];
            edp = m_dd[digit];
            ean = (slot_pos >= GUARD) ? 4'(1 << digit) : 4'h0;
        end
        bnd = (k % FRAME) == FRAME - 1;
        if (load) begin
            m_sv = value; m_sd = dp; m_sb = blank;
            if (bnd) begin
                m_dv = value; m_dd = dp; m_db = blank; m_pend = 1'b0;
            end else begin
                m_pend = 1'b1;
            end
        end else if (bnd && m_pend) begin
            m_dv = m_sv; m_dd = m_sd; m_db = m_sb; m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
        k++;
        chk("seg", {1'b0, seg}, {1'b0, ~es});
        chk("dp", {7'b0, dpo}, {7'b0, ~edp});
        chk("an", {4'b0, an}, {4'b0, ~ean});
        chk("frame", {7'b0, frame}, {7'b0, ((k % FRAME) == FRAME - 1)});
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < FRAME && (k % FRAME) != pos; i++) step();
    endtask

    task automatic model_reset();
        k = 0;
        m_dv = '0; m_sv = '0; m_dd = '0; m_sd = '0; m_db = '0; m_sb = '0;
        m_pend = 1'b0;
    endtask

    initial begin
        // Reset state, then two idle frames showing 0000.
        repeat (3) @(posedge clk);
        #1;
        chk_dark("reset");
        rst = 1'b0;
        model_reset();
        run(2 * FRAME);

        // Load mid-frame: display waits for the boundary.
        run_to(5);
        value = 16'h12AF;
        load  = 1'b1;
        step();
        run(2 * FRAME);

        // Leading-zero suppression on, then off.
        value = 16'h0030;
        load  = 1'b1;
        lz    = 1'b1;
        step();
        run(2 * FRAME);
        lz = 1'b0;
        run(FRAME);

        // Blank digit 2, decimal point on digit 0.
        value = 16'h4321;
        blank = 4'b0100;
        dp    = 4'b0001;
        load  = 1'b1;
        step();
        run(2 * FRAME);
        blank = 4'b0000;
        dp    = 4'b0000;

        // Load exactly in the boundary cycle.
        run_to(FRAME - 1);
        value = 16'h5555;
        load  = 1'b1;
        step();
        run(2 * FRAME);

        // Asynchronous reset mid-slot with a pending load.
        value = 16'h9876;
        dp    = 4'b1010;
        load  = 1'b1;
        step();
        run(10);
        #2;
        rst = 1'b1;
        #1;
        chk_dark("async_rst");
        @(posedge clk);
        #1;
        chk_dark("rst_hold");
        rst = 1'b0;
        dp  = 4'b0000;
        model_reset();
        run(2 * FRAME);

        // Randomised loads, blanks, decimal points and suppression toggles.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                value = 16'($urandom);
                if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
                dp    = 4'($urandom);
                blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                load  = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) lz = ~lz;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
